uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (16).
REQ-002 Single clock domain; reset is synchronous and active-high.
REQ-003 mclk  input  1  master clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_en  input  1  enqueue request; one byte per cycle while high.
REQ-007 full  output  1  high when count == 2**DEPTH_LOG2.
REQ-008 empty  output  1  high when count == 0.
REQ-009 count  output  DEPTH_LOG2+1  bytes currently stored, excluding the byte already handed to the transmitter.
REQ-010 overflow  output  1  one-cycle pulse when a write is rejected.
REQ-011 tx_ready  input  1  transmitter idle and able to accept a byte; connected to the uart_tx ready output.
REQ-012 tx_data  output  8  byte presented to the transmitter.
REQ-013 tx_strobe  output  1  one-cycle load pulse to the transmitter.

Function
REQ-014 Storage: circular buffer with DEPTH_LOG2-bit read and write pointers; both pointers wrap modulo depth.
REQ-015 Write: when wr_en=1 and full=0 at the clock edge, store wr_data at the write pointer, then advance the write pointer.
REQ-016 Write when full: when wr_en=1 and full=1, the byte is dropped, no state changes, and overflow=1 on the next cycle only.
REQ-017 Full is evaluated before any same-cycle pop, so a write is rejected even if a pop occurs in the same cycle.
REQ-018 Simultaneous push and pop with 0<count<depth: count is unchanged and both pointers advance.
REQ-019 Drain FSM states: IDLE, WAIT_LOW, WAIT_HIGH.
REQ-020 IDLE: when empty=0 and tx_ready=1, register tx_data from the head byte, assert tx_strobe on the next cycle, advance the read pointer, and move to WAIT_LOW.
REQ-021 IDLE with empty=1 or tx_ready=0: remain in IDLE.
REQ-022 WAIT_LOW: remain until tx_ready=0, then move to WAIT_HIGH.
REQ-023 WAIT_LOW also moves to WAIT_HIGH after 4 cycles without tx_ready=0; this covers the transmitter's registered ready lagging the strobe.
REQ-024 WAIT_HIGH: remain until tx_ready=1, then move to IDLE.
REQ-025 tx_strobe is high for exactly one cycle per dequeued byte.
REQ-026 Consecutive tx_strobe pulses are at least 3 cycles apart.
REQ-027 tx_data is held stable from each strobe until the next strobe.
REQ-028 Latency: a write at edge N into an empty FIFO, with the FSM in IDLE and tx_ready=1, gives tx_strobe=1 during cycle N+2 with tx_data equal to that byte.
REQ-029 count increments on an accepted write and decrements on a pop; it never exceeds depth and never underflows.
REQ-030 Bytes are delivered in write order; none are duplicated or lost except those rejected on overflow.

Reset
REQ-031 Reset values: pointers=0, count=0, FSM=IDLE, empty=1, full=0, overflow=0, tx_strobe=0, tx_data=8'h00.
REQ-032 Reset has priority over wr_en and tx_ready in the same cycle.
REQ-033 Reset mid-transfer discards all stored bytes, and no strobe is issued in the cycle after reset.
REQ-034 Storage contents need no reset.

Verification
REQ-035 Single byte: write 8'hA5 with tx_ready=1 -> one tx_strobe 2 cycles later with tx_data=8'hA5; count returns to 0; empty=1.
REQ-036 Fill/overflow: tx_ready=0, write 17 bytes 8'h00..8'h10 -> full=1 after the 16th byte; a single overflow pulse on the 17th; count=16.
REQ-037 Drain order: from the previous state, model uart_tx ready behaviour (low 1 cycle after strobe, high after 10 bit times) -> 16 strobes with data 8'h00..8'h0F in order, each ≥3 cycles apart.
REQ-038 Wrap-around: 40 bytes streamed with concurrent writes and drains -> all received in order; pointers wrap twice; count never exceeds 16.
REQ-039 Reset mid-operation: assert reset with count=5 while the FSM is in WAIT_HIGH -> next cycle count=0, empty=1, FSM=IDLE; no strobe until a new write.
REQ-040 Stuck-ready: tx_ready held at 1 constantly, write 3 bytes -> strobes spaced exactly 6 cycles apart (4-cycle WAIT_LOW timeout + WAIT_HIGH + IDLE), data in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter.
// Writers push bytes into a circular buffer. A small drain FSM hands the
// head byte to the transmitter with a one-cycle strobe, then waits for the
// transmitter's ready to drop and rise again before sending the next byte.
// The WAIT_LOW state has a timeout, so a transmitter whose ready never drops
// cannot stall the FIFO.

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_strobe
);

    localparam int                       DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]      DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]      CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0]    PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  overflow_q;
    state_t                state_q;
    logic [1:0]            wait_cnt_q;
    logic [7:0]            tx_data_q;
    logic                  tx_strobe_q;

    logic                  push;
    logic                  pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for a write that arrived while the FIFO was full.
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = (state_q == IDLE) && !empty && tx_ready;

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_data   = tx_data_q;
    assign tx_strobe = tx_strobe_q;

    // Next occupancy: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Byte storage. It is left unreset because the pointers define validity.
    always_ff @(posedge mclk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy and the overflow pulse for a rejected write.
    always_ff @(posedge mclk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            overflow_q <= wr_en && full;
        end
    end

    // Drain FSM. It hands one byte to the transmitter, then waits out the
    // transmitter's busy period; the strobe and data are registered.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 2'd0;
            tx_data_q   <= 8'h00;
            tx_strobe_q <= 1'b0;
        end else begin
            tx_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q   <= mem_q[rd_ptr_q];
                        tx_strobe_q <= 1'b1;
                        wait_cnt_q  <= 2'd0;
                        state_q     <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!tx_ready || (wait_cnt_q == 2'd3)) begin
                        state_q <= WAIT_HIGH;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (tx_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// A short table of single-cycle vectors covers reset, one-byte latency and
// the FSM handshake. Hand-written sequences then cover fill/overflow, drain
// order against a transmitter ready model, pointer wrap-around, reset in the
// middle of a transfer and a transmitter whose ready is stuck high.

module tb_uart_tx_fifo;

    localparam int DepthLog2 = 4;

    logic                 mclk = 1'b0;
    logic                 reset;
    logic [7:0]           wrData;
    logic                 wrEn;
    logic                 full;
    logic                 empty;
    logic [DepthLog2:0]   count;
    logic                 overflow;
    logic                 txReady;
    logic [7:0]           txData;
    logic                 txStrobe;

    typedef struct {
        logic       rst;
        logic       wrEn;
        logic [7:0] wrData;
        logic       txReady;
        logic       expFull;
        logic       expEmpty;
        logic [4:0] expCount;
        logic       expOverflow;
        logic       expStrobe;
        logic [7:0] expData;
    } vector_t;

    vector_t    vecs [11];

    int         errors = 0;
    int         checks = 0;
    int         cycleNo = 0;

    logic [7:0] expQ [$];
    logic       sbOn = 1'b0;
    logic       haveStrobe = 1'b0;
    logic [7:0] lastData = 8'h00;
    int         lastStrobeCycle = -1;
    int         strobeCount = 0;
    logic       stuckMode = 1'b0;
    logic       chkBounds = 1'b0;

    logic       modelOn = 1'b0;
    logic       strobePrev = 1'b0;
    int         busy = 0;
    int         busyLen = 10;

    uart_tx_fifo #(
        .DEPTH_LOG2(DepthLog2)
    ) dut (
        .mclk      (mclk),
        .reset     (reset),
        .wr_data   (wrData),
        .wr_en     (wrEn),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_ready  (txReady),
        .tx_data   (txData),
        .tx_strobe (txStrobe)
    );

    // Free-running master clock, 10 time units per period.
    always #5 mclk = ~mclk;

    // Hard time limit so the run always ends even if the design hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        reset   = v.rst;
        wrEn    = v.wrEn;
        wrData  = v.wrData;
        txReady = v.txReady;
    endtask

    // Advance one clock, then sample outputs 1 unit after the edge. Runs the
    // strobe scoreboard and, when enabled, the transmitter ready model.
    task automatic stepCycle();
        logic [7:0] expByte;
        int gap;
        @(posedge mclk);
        #1;
        cycleNo++;
        if (sbOn) begin
            if (txStrobe) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedStrobe: got strobe with data %0h expected no strobe (cycle %0d)", txData, cycleNo);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("strobeData", 32'(txData), 32'(expByte));
                end
                if (lastStrobeCycle >= 0) begin
                    gap = cycleNo - lastStrobeCycle;
                    if (stuckMode) begin
                        checkOutput("strobeGapExact", 32'(gap), 32'd6);
                    end else begin
                        checks++;
                        if (gap < 3) begin
                            errors++;
                            $display("[TB] FAIL strobeGapMin: got gap %0d expected at least 3 (cycle %0d)", gap, cycleNo);
                        end
                    end
                end
                lastStrobeCycle = cycleNo;
                lastData        = txData;
                haveStrobe      = 1'b1;
                strobeCount++;
            end else if (haveStrobe) begin
                checkOutput("dataHold", 32'(txData), 32'(lastData));
            end
        end
        if (chkBounds) begin
            checks++;
            if ((count > 5'd16) || (overflow !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL bounds: got count %0d overflow %0b expected count<=16 overflow 0 (cycle %0d)", count, overflow, cycleNo);
            end
        end
        if (modelOn) begin
            if (strobePrev) begin
                txReady = 1'b0;
                busy    = busyLen;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    txReady = 1'b1;
                end
            end
            strobePrev = txStrobe;
        end
    endtask

    task automatic doReset();
        expQ.delete();
        haveStrobe      = 1'b0;
        lastStrobeCycle = -1;
        strobeCount     = 0;
        strobePrev      = 1'b0;
        busy            = 0;
        reset           = 1'b1;
        wrEn            = 1'b0;
        wrData          = 8'h00;
        stepCycle();
        reset           = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        wrEn    = 1'b0;
        wrData  = 8'h00;
        txReady = 1'b1;

        // rst wr data rdy | full empty count ovf stb data
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h11};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h11};
        vecs[9]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};

        // Table phase: each vector is sampled at one edge, outputs checked after it.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d.full", i),     32'(full),     32'(vecs[i].expFull));
            checkOutput($sformatf("vec%0d.empty", i),    32'(empty),    32'(vecs[i].expEmpty));
            checkOutput($sformatf("vec%0d.count", i),    32'(count),    32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].expOverflow));
            checkOutput($sformatf("vec%0d.strobe", i),   32'(txStrobe), 32'(vecs[i].expStrobe));
            checkOutput($sformatf("vec%0d.data", i),     32'(txData),   32'(vecs[i].expData));
        end

        // Fill with transmitter busy, then one write too many.
        sbOn    = 1'b1;
        modelOn = 1'b0;
        txReady = 1'b0;
        doReset();
        for (int i = 0; i < 17; i++) begin
            wrEn   = 1'b1;
            wrData = 8'(i);
            stepCycle();
            checkOutput($sformatf("fill%0d.count", i),    32'(count),    (i < 16) ? 32'(i + 1) : 32'd16);
            checkOutput($sformatf("fill%0d.full", i),     32'(full),     (i >= 15) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill%0d.overflow", i), 32'(overflow), (i == 16) ? 32'd1 : 32'd0);
        end
        wrEn = 1'b0;
        stepCycle();
        checkOutput("fillEnd.overflow", 32'(overflow), 32'd0);
        checkOutput("fillEnd.count",    32'(count),    32'd16);

        // Drain with the ready model; the write in the first pop cycle is rejected.
        for (int i = 0; i < 16; i++) begin
            expQ.push_back(8'(i));
        end
        modelOn = 1'b1;
        busyLen = 10;
        txReady = 1'b1;
        wrEn    = 1'b1;
        wrData  = 8'h99;
        stepCycle();
        wrEn = 1'b0;
        checkOutput("popWhileFull.count",    32'(count),    32'd15);
        checkOutput("popWhileFull.overflow", 32'(overflow), 32'd1);
        checkOutput("popWhileFull.strobe",   32'(txStrobe), 32'd1);
        for (int n = 0; n < 400 && expQ.size() > 0; n++) begin
            stepCycle();
        end
        checkOutput("drain.remaining", 32'(expQ.size()), 32'd0);
        checkOutput("drain.strobes",   32'(strobeCount), 32'd16);
        repeat (20) stepCycle();
        checkOutput("drain.empty", 32'(empty), 32'd1);

        // Wrap-around: four bursts of ten bytes with concurrent draining.
        modelOn = 1'b0;
        txReady = 1'b1;
        doReset();
        modelOn   = 1'b1;
        busyLen   = 3;
        chkBounds = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                wrEn   = 1'b1;
                wrData = 8'(8'h80 + b * 10 + i);
                expQ.push_back(wrData);
                stepCycle();
            end
            wrEn = 1'b0;
            repeat (60) stepCycle();
        end
        for (int n = 0; n < 300 && expQ.size() > 0; n++) begin
            stepCycle();
        end
        chkBounds = 1'b0;
        checkOutput("wrap.remaining", 32'(expQ.size()), 32'd0);
        checkOutput("wrap.strobes",   32'(strobeCount), 32'd40);

        // Reset while five bytes wait and the FSM sits in WAIT_HIGH.
        modelOn = 1'b0;
        txReady = 1'b1;
        doReset();
        modelOn = 1'b1;
        busyLen = 10;
        for (int i = 0; i < 6; i++) begin
            wrEn   = 1'b1;
            wrData = 8'(8'h50 + i);
            expQ.push_back(wrData);
            stepCycle();
        end
        wrEn = 1'b0;
        stepCycle();
        checkOutput("preReset.count",   32'(count),       32'd5);
        checkOutput("preReset.strobes", 32'(strobeCount), 32'd1);
        modelOn = 1'b0;
        doReset();
        txReady = 1'b1;
        checkOutput("midReset.count",  32'(count),    32'd0);
        checkOutput("midReset.empty",  32'(empty),    32'd1);
        checkOutput("midReset.full",   32'(full),     32'd0);
        checkOutput("midReset.strobe", 32'(txStrobe), 32'd0);
        checkOutput("midReset.data",   32'(txData),   32'd0);
        for (int n = 0; n < 8; n++) begin
            stepCycle();
            checkOutput($sformatf("postReset%0d.strobe", n), 32'(txStrobe), 32'd0);
        end
        wrEn   = 1'b1;
        wrData = 8'h77;
        expQ.push_back(8'h77);
        stepCycle();
        wrEn = 1'b0;
        checkOutput("latency.strobeEarly", 32'(txStrobe), 32'd0);
        stepCycle();
        checkOutput("latency.strobe", 32'(txStrobe), 32'd1);
        checkOutput("latency.data",   32'(txData),   32'h77);
        repeat (15) stepCycle();

        // Ready stuck high: strobes paced only by the WAIT_LOW timeout.
        modelOn = 1'b0;
        txReady = 1'b1;
        doReset();
        stuckMode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrEn   = 1'b1;
            wrData = 8'(8'h31 + i);
            expQ.push_back(wrData);
            stepCycle();
        end
        wrEn = 1'b0;
        for (int n = 0; n < 40 && strobeCount < 3; n++) begin
            stepCycle();
        end
        repeat (10) stepCycle();
        stuckMode = 1'b0;
        checkOutput("stuck.strobes",   32'(strobeCount), 32'd3);
        checkOutput("stuck.remaining", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
